// File: rtl/spike_readout_argmax_if.sv
// spike_readout_argmax_if: request, spike and result bundle for the argmax readout.
// Handshake: start_i is a level sampled on each clk edge and is taken only while the
// block is idle. valid_o is a one-cycle strobe with no ready. The consumer must take
// class_o/max_count_o/tie_o while valid_o is high. Those values then hold until the
// next strobe or a reset. state_o is a debug view of the controller state.
interface spike_readout_argmax_if #(
  parameter int NUM_CLASSES = 10,
  parameter int WIDTH_P     = 8
);
  logic                   start_i;
  logic [NUM_CLASSES-1:0] spike_i;
  logic [3:0]             sel_i;
  logic [WIDTH_P-1:0]     sel_count_o;
  logic [3:0]             class_o;
  logic [WIDTH_P-1:0]     max_count_o;
  logic                   tie_o;
  logic                   valid_o;
  logic                   busy_o;
  logic [1:0]             state_o;

  modport master (
    output start_i, spike_i, sel_i,
    input  sel_count_o, class_o, max_count_o, tie_o, valid_o, busy_o, state_o
  );

  modport slave (
    input  start_i, spike_i, sel_i,
    output sel_count_o, class_o, max_count_o, tie_o, valid_o, busy_o, state_o
  );
endinterface

// File: rtl/spike_readout_argmax.sv
// spike_readout_argmax: counts spikes per class over a fixed window, then scans the
// counters one class per cycle to find the argmax. Ties go to the lowest index and
// raise the tie flag.
// Optional build macro SPIKE_READOUT_AUTORESTART_EN: after the first start, every
// result is followed at once by a fresh window, so windows run back-to-back.
module spike_readout_argmax #(
  parameter int NUM_CLASSES = 10,
  parameter int WIDTH_P     = 8,
  parameter int WINDOW_LEN  = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  spike_readout_argmax_if.slave bus
);
  localparam int               WIN_W    = $clog2(WINDOW_LEN + 1);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_LEN - 1);
  localparam logic [3:0]       IDX_LAST = 4'(NUM_CLASSES - 1);
  localparam logic [4:0]       NUM_C5   = 5'(NUM_CLASSES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    SCAN  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             r_state;
  logic [WIDTH_P-1:0] r_cnt [NUM_CLASSES];
  logic [WIN_W-1:0]   r_win;
  logic [3:0]         r_idx;
  logic [WIDTH_P-1:0] r_best;
  logic [3:0]         r_best_idx;
  logic               r_tie;
  logic [3:0]         r_class;
  logic [WIDTH_P-1:0] r_max;
  logic               r_tie_q;
  logic               r_valid;
  logic               r_busy;

  logic [WIDTH_P-1:0] w_scan_cnt;
  logic [WIDTH_P-1:0] w_sel_cnt;

  // Counter under the scan pointer; reads 0 once the pointer runs past the last class.
  always_comb begin
    w_scan_cnt = '0;
    if ({1'b0, r_idx} < NUM_C5) w_scan_cnt = r_cnt[r_idx];
  end

  // Debug readback of one counter; indices beyond the class count read as 0.
  always_comb begin
    w_sel_cnt = '0;
    if ({1'b0, bus.sel_i} < NUM_C5) w_sel_cnt = r_cnt[bus.sel_i];
  end

  // Controller: window counting, sequential argmax scan and result registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_win      <= '0;
      r_idx      <= '0;
      r_best     <= '0;
      r_best_idx <= '0;
      r_tie      <= 1'b0;
      r_class    <= '0;
      r_max      <= '0;
      r_tie_q    <= 1'b0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      for (int i = 0; i < NUM_CLASSES; i++) r_cnt[i] <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          r_busy <= 1'b0;
          if (bus.start_i) begin
            for (int i = 0; i < NUM_CLASSES; i++) r_cnt[i] <= '0;
            r_win   <= '0;
            r_busy  <= 1'b1;
            r_state <= COUNT;
          end
        end
        COUNT: begin
          r_busy <= 1'b1;
          // Saturating increment: a full counter simply holds.
          for (int i = 0; i < NUM_CLASSES; i++) begin
            if (bus.spike_i[i] && (r_cnt[i] != '1)) r_cnt[i] <= r_cnt[i] + WIDTH_P'(1);
          end
          r_win <= r_win + WIN_W'(1);
          if (r_win == WIN_LAST) begin
            r_idx      <= '0;
            r_best     <= '0;
            r_best_idx <= '0;
            r_tie      <= 1'b0;
            r_state    <= SCAN;
          end
        end
        SCAN: begin
          r_busy <= 1'b1;
          // Strict greater-than keeps the lowest index on equal counts.
          if ((w_scan_cnt > r_best) || (r_idx == 4'd0)) begin
            r_best     <= w_scan_cnt;
            r_best_idx <= r_idx;
            r_tie      <= 1'b0;
          end else if (w_scan_cnt == r_best) begin
            r_tie <= 1'b1;
          end
          r_idx <= r_idx + 4'd1;
          if (r_idx == IDX_LAST) r_state <= DONE;
        end
        DONE: begin
          r_class <= r_best_idx;
          r_max   <= r_best;
          r_tie_q <= r_tie;
          r_valid <= 1'b1;
          // Busy stays up for the cycle in which valid is shown.
          r_busy  <= 1'b1;
`ifdef SPIKE_READOUT_AUTORESTART_EN
          for (int i = 0; i < NUM_CLASSES; i++) r_cnt[i] <= '0;
          r_win   <= '0;
          r_state <= COUNT;
`else
          r_state <= IDLE;
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.sel_count_o = w_sel_cnt;
  assign bus.class_o     = r_class;
  assign bus.max_count_o = r_max;
  assign bus.tie_o       = r_tie_q;
  assign bus.valid_o     = r_valid;
  assign bus.busy_o      = r_busy;
  assign bus.state_o     = r_state;
endmodule

// File: tb/tb_spike_readout_argmax.sv
// tb_spike_readout_argmax: directed checks of the argmax readout.
// dut_d uses the default parameters (window 255, latency 266).
// dut_s uses a 20-cycle window and 4-bit counters (latency 31).
module tb_spike_readout_argmax;
  logic clk = 1'b0;
  logic rst_d_n;
  logic rst_s_n;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_checks = 0;
  int   n_valid_s = 0;
  int   spk_n [10];
  int   k, t, v1, nv;
  logic [12:0] exp_q [$];

  spike_readout_argmax_if #(.NUM_CLASSES(10), .WIDTH_P(8)) ifd ();
  spike_readout_argmax_if #(.NUM_CLASSES(10), .WIDTH_P(4)) ifs ();

  spike_readout_argmax #(.NUM_CLASSES(10), .WIDTH_P(8), .WINDOW_LEN(255)) dut_d (
    .clk_i (clk),
    .rst_ni(rst_d_n),
    .bus   (ifd.slave)
  );

  spike_readout_argmax #(.NUM_CLASSES(10), .WIDTH_P(4), .WINDOW_LEN(20)) dut_s (
    .clk_i (clk),
    .rst_ni(rst_s_n),
    .bus   (ifs.slave)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (ifs.valid_o === 1'b1) n_valid_s++;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
  endtask

  // Default DUT: one class spikes for the whole run; optional ignored start mid-window.
  task automatic run_d(input int cls, input int mid_start, input logic [3:0] e_class,
                       input logic [7:0] e_max, input logic e_tie, input string tag);
    int kk, tt;
    logic [12:0] e;
    exp_q.push_back({e_class, e_max, e_tie});
    ifd.start_i = 1'b1;
    @(posedge clk); #1;
    ifd.start_i = 1'b0;
    kk = cyc;
    ifd.spike_i = '0;
    ifd.spike_i[cls] = 1'b1;
    for (int j = 0; j < 255; j++) begin
      ifd.start_i = (j == mid_start);
      @(posedge clk); #1;
    end
    ifd.start_i = 1'b0;
    tt = 0;
    while (ifd.valid_o !== 1'b1 && tt < 400) begin
      @(posedge clk); #1;
      tt++;
    end
    check({tag, " in_time"}, 32'(tt < 400), 1);
    check({tag, " latency"}, cyc - kk, 266);
    check({tag, " queue"}, exp_q.size(), 1);
    e = exp_q.pop_front();
    check({tag, " class"}, ifd.class_o, e[12:9]);
    check({tag, " max"}, ifd.max_count_o, e[8:1]);
    check({tag, " tie"}, ifd.tie_o, e[0]);
    check({tag, " busy_at_valid"}, ifd.busy_o, 1);
    @(posedge clk); #1;
    check({tag, " valid_fall"}, ifd.valid_o, 0);
    check({tag, " busy_fall"}, ifd.busy_o, 0);
    ifd.spike_i = '0;
  endtask

  // Small DUT: class c spikes in the first spk_n[c] cycles of the window; all-ones
  // spikes are driven after the window and must be ignored.
  task automatic run_s(input logic [3:0] e_class, input logic [3:0] e_max,
                       input logic e_tie, input string tag);
    int kk, tt;
    logic [12:0] e;
    exp_q.push_back({e_class, 4'd0, e_max, e_tie});
    ifs.start_i = 1'b1;
    @(posedge clk); #1;
    ifs.start_i = 1'b0;
    kk = cyc;
    for (int j = 0; j < 20; j++) begin
      for (int c = 0; c < 10; c++) ifs.spike_i[c] = (j < spk_n[c]);
      @(posedge clk); #1;
    end
    ifs.spike_i = '1;
    tt = 0;
    while (ifs.valid_o !== 1'b1 && tt < 100) begin
      @(posedge clk); #1;
      tt++;
    end
    check({tag, " in_time"}, 32'(tt < 100), 1);
    check({tag, " latency"}, cyc - kk, 31);
    check({tag, " queue"}, exp_q.size(), 1);
    e = exp_q.pop_front();
    check({tag, " class"}, ifs.class_o, e[12:9]);
    check({tag, " max"}, ifs.max_count_o, e[8:1]);
    check({tag, " tie"}, ifs.tie_o, e[0]);
    @(posedge clk); #1;
    check({tag, " valid_fall"}, ifs.valid_o, 0);
    ifs.spike_i = '0;
  endtask

  initial begin
    // reset
    rst_d_n = 1'b0;
    rst_s_n = 1'b0;
    ifd.start_i = 1'b0; ifd.spike_i = '0; ifd.sel_i = 4'd3;
    ifs.start_i = 1'b0; ifs.spike_i = '0; ifs.sel_i = 4'd3;
    repeat (2) @(posedge clk);
    #1;
    check("rst class", ifd.class_o, 0);
    check("rst max", ifd.max_count_o, 0);
    check("rst tie", ifd.tie_o, 0);
    check("rst valid", ifd.valid_o, 0);
    check("rst busy", ifd.busy_o, 0);
    check("rst state", ifd.state_o, 0);
    rst_d_n = 1'b1;
    rst_s_n = 1'b1;
    ifd.spike_i = '1;
    ifs.spike_i = '1;
    repeat (5) @(posedge clk);
    #1;
    check("idle spikes ignored", ifd.sel_count_o, 0);
    check("idle busy", ifd.busy_o, 0);
    check("idle state", ifd.state_o, 0);
    ifd.spike_i = '0;
    ifs.spike_i = '0;

`ifdef SPIKE_READOUT_AUTORESTART_EN
    // back-to-back windows from a single start
    ifd.start_i = 1'b1;
    @(posedge clk); #1;
    ifd.start_i = 1'b0;
    k = cyc;
    ifd.spike_i = 10'b00_0000_0010;
    t = 0;
    while (ifd.valid_o !== 1'b1 && t < 400) begin
      @(posedge clk); #1;
      t++;
    end
    check("ar w1 latency", cyc - k, 266);
    check("ar w1 class", ifd.class_o, 1);
    check("ar w1 max", ifd.max_count_o, 255);
    v1 = cyc;
    ifd.spike_i = 10'b01_0000_0000;
    @(posedge clk); #1;
    check("ar busy held", ifd.busy_o, 1);
    check("ar state count", ifd.state_o, 1);
    t = 0;
    while (ifd.valid_o !== 1'b1 && t < 400) begin
      @(posedge clk); #1;
      t++;
    end
    check("ar period", cyc - v1, 266);
    check("ar w2 class", ifd.class_o, 8);
    check("ar w2 max", ifd.max_count_o, 255);
    check("ar w2 busy", ifd.busy_o, 1);
    ifd.spike_i = '0;
`else
    // single winner with defaults
    run_d(3, -1, 4'd3, 8'd255, 1'b0, "win3");
    ifd.sel_i = 4'd3; #1;
    check("win3 sel3", ifd.sel_count_o, 255);
    ifd.sel_i = 4'd4; #1;
    check("win3 sel4", ifd.sel_count_o, 0);
    ifd.sel_i = 4'd12; #1;
    check("win3 sel_oob", ifd.sel_count_o, 0);

    // start re-asserted mid-window is ignored; counters were cleared by the new start
    run_d(6, 100, 4'd6, 8'd255, 1'b0, "midstart");
    ifd.sel_i = 4'd3; #1;
    check("midstart sel3 cleared", ifd.sel_count_o, 0);
    ifd.sel_i = 4'd6; #1;
    check("midstart sel6", ifd.sel_count_o, 255);

    // tie: classes 2 and 7 at 10, class 0 at 4
    spk_n = '{4, 0, 10, 0, 0, 0, 0, 10, 0, 0};
    run_s(4'd2, 4'd10, 1'b1, "tie");
    ifs.sel_i = 4'd7; #1;
    check("tie sel7", ifs.sel_count_o, 10);
    ifs.sel_i = 4'd0; #1;
    check("tie sel0 held", ifs.sel_count_o, 4);

    // higher index strictly greater wins
    spk_n = '{0, 0, 0, 0, 12, 0, 0, 0, 0, 13};
    run_s(4'd9, 4'd13, 1'b0, "hi_idx");

    // silence: everyone ties at 0
    spk_n = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run_s(4'd0, 4'd0, 1'b1, "silence");

    // saturation at 4 bits
    spk_n = '{0, 0, 0, 0, 0, 20, 0, 0, 0, 0};
    run_s(4'd5, 4'd15, 1'b0, "sat");
    ifs.sel_i = 4'd5; #1;
    check("sat sel5", ifs.sel_count_o, 15);

    // reset during SCAN: outputs cleared, no result pulse
    ifs.start_i = 1'b1;
    @(posedge clk); #1;
    ifs.start_i = 1'b0;
    ifs.spike_i = 10'b00_0010_0000;
    repeat (20) @(posedge clk);
    #1;
    ifs.spike_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("abort in_scan", ifs.state_o, 2);
    rst_s_n = 1'b0;
    @(posedge clk); #1;
    rst_s_n = 1'b1;
    check("abort class", ifs.class_o, 0);
    check("abort max", ifs.max_count_o, 0);
    check("abort tie", ifs.tie_o, 0);
    check("abort busy", ifs.busy_o, 0);
    check("abort state", ifs.state_o, 0);
    check("abort sel5", ifs.sel_count_o, 0);
    nv = n_valid_s;
    repeat (40) @(posedge clk);
    #1;
    check("abort no_valid", n_valid_s, nv);
    check("abort idle", ifs.state_o, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/spike_readout_argmax.md
# spike_readout_argmax

Windowed winner-take-all readout for the spiking classifier. Sits directly downstream of the output LIF layer. It counts `spike_i` pulses per class over a fixed window of cycles, then scans the per-class counters sequentially to find the argmax. It presents the winning class index, its count and a tie flag with a one-cycle valid pulse, replacing direct exposure of raw spike counts on the output pins.

## Interface
- `NUM_CLASSES`, default 10: number of output neurons/classes; range 2..16.
- `WIDTH_P`, default 8: per-class counter width.
- `WINDOW_LEN`, default 255: integration window in cycles; must be ≥1.

Clock is `clk_i`. Reset is `rst_ni`, synchronous and active-low.

- `clk_i`  in  1  clock.
- `rst_ni`  in  1  synchronous active-low reset.
- `start_i`  in  1  starts one window; honoured only in IDLE.
- `spike_i`  in  NUM_CLASSES  output-layer spikes, one bit per class.
- `sel_i`  in  4  class index for the debug counter readback.
- `sel_count_o`  out  WIDTH_P  combinational view of counter[`sel_i`]; 0 if `sel_i` ≥ NUM_CLASSES.
- `class_o`  out  4  registered winning class index.
- `max_count_o`  out  WIDTH_P  registered count of the winner.
- `tie_o`  out  1  registered; 1 if another class equals the winner's count.
- `valid_o`  out  1  one-cycle pulse when `class_o`, `max_count_o` and `tie_o` update.
- `busy_o`  out  1  high in COUNT, SCAN and DONE.

## Operation
- **States:** IDLE, COUNT, SCAN, DONE.
- **Reset:** state IDLE, all counters 0. `class_o`, `max_count_o`, `tie_o`, `valid_o` and `busy_o` are all 0.
- **IDLE:**
  - If `start_i`=1: clear all counters and the window counter, then go to COUNT.
  - Otherwise stay in IDLE.
  - `spike_i` is ignored.
- **COUNT:**
  - Each cycle, for every i with `spike_i[i]`=1, counter[i] increments, saturating at 2^WIDTH_P−1. A saturated counter holds its value.
  - The window counter increments each cycle. After WINDOW_LEN sampled cycles, go to SCAN.
  - Initialise SCAN with idx=0, best=0, best_idx=0, tie=0.
- **SCAN:** one class per cycle, idx = 0..NUM_CLASSES−1.
  - If counter[idx] > best, or idx=0: best←counter[idx], best_idx←idx, tie←0.
  - Else if counter[idx] == best: tie←1.
  - On ties the lowest index wins.
  - After idx=NUM_CLASSES−1, go to DONE.
- **DONE:** lasts one cycle.
  - Register best_idx → `class_o`, best → `max_count_o`, tie → `tie_o`.
  - Assert `valid_o` for that single cycle, then go to IDLE.
- **Held state:**
  - Counters keep their window values until the next accepted start, so `sel_count_o` remains readable after a result.
  - Result outputs hold until the next DONE or a reset.
- **Ignored inputs:**
  - `start_i` in COUNT, SCAN or DONE is ignored; it is not queued.
  - `spike_i` outside COUNT is ignored.

## Timing
- The start is accepted at edge k. Spikes are sampled at edges k+1..k+WINDOW_LEN.
- SCAN occupies edges k+WINDOW_LEN+1..k+WINDOW_LEN+NUM_CLASSES.
- Outputs update and `valid_o` rises at edge k+WINDOW_LEN+NUM_CLASSES+1; `valid_o` falls at the following edge.
- Start-to-valid latency is WINDOW_LEN+NUM_CLASSES+1 cycles, which is 266 with the defaults.
- `busy_o` is high from edge k to edge k+WINDOW_LEN+NUM_CLASSES+1, falling together with `valid_o` at the edge after.
- `rst_ni`=0 at any edge, including mid-COUNT or mid-SCAN, returns the block to reset state on that edge. No partial result is produced.
- The window counter must hold WINDOW_LEN; size it as $clog2(WINDOW_LEN+1) bits.

## Configuration
- Macro: `SPIKE_READOUT_AUTORESTART_EN`.
  - **Defined:** DONE goes directly to COUNT, clearing the counters on that same edge, so windows run back-to-back every WINDOW_LEN+NUM_CLASSES+1 cycles. The first window still requires `start_i` from IDLE. `busy_o` stays high continuously.
  - **Undefined:** DONE returns to IDLE and waits for `start_i`.

## Test plan
- **Reset:** assert `rst_ni`=0 for 2 cycles → all outputs 0 and `busy_o`=0. Hold `start_i`=0 and drive spikes → counters stay 0.
- **Single winner (defaults):** pulse `start_i`, then hold `spike_i[3]`=1 for the whole window → `valid_o` pulses exactly 266 cycles after start with `class_o`=3, `max_count_o`=255, `tie_o`=0. `sel_i`=3 gives `sel_count_o`=255.
- **Tie:** with WINDOW_LEN=20, give classes 2 and 7 10 spikes each and class 0 4 spikes → `class_o`=2, `max_count_o`=10, `tie_o`=1.
- **Saturation and silence:**
  - With WIDTH_P=4 and WINDOW_LEN=20, drive class 5 spiking every cycle → `max_count_o`=15, `class_o`=5.
  - With no spikes → `class_o`=0, `max_count_o`=0, `tie_o`=1.
- **Abort and ignore:**
  - `start_i` re-asserted mid-COUNT → latency unchanged.
  - `rst_ni` low mid-SCAN → no `valid_o` pulse, outputs 0, state IDLE.
- **Autorestart:** with `SPIKE_READOUT_AUTORESTART_EN` defined and a single start, drive class 1 in window 1 and class 8 in window 2 → `valid_o` pulses 266 cycles apart with `class_o`=1 then 8.
